// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial add sequencer: FSM state encoding and its width.
package serial_add_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full adder cell; the one datapath slice time-shared by the serial controller.
module serial_add_ctrl_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co,
    output logic p
);

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (p & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: one FA reused LSB-first over W clocks, valid/ready on both sides.
// Optional early termination when no carry and no operand bits remain: SERIAL_ADD_EARLY_DONE_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    input  logic          Cin,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [W-1:0]  S,
    output logic          Cout,
    output logic          P,
    output logic [CW-1:0] cycles
);

    localparam logic [CW-1:0] LAST_K = CW'(W - 1);

    state_e        state_r, state_s;
    logic [W-1:0]  a_sh_r, a_sh_s;
    logic [W-1:0]  b_sh_r, b_sh_s;
    logic [W-1:0]  sum_r, sum_s;
    logic          carry_r, carry_s;
    logic          cout_r, cout_s;
    logic          p_r, p_s;
    // Doubles as the bit index k: both start at 0 and advance once per RUN cycle.
    logic [CW-1:0] cnt_r, cnt_s;
    logic          fa_sum_s, fa_co_s, fa_p_s;
    logic          early_s, last_s;

    serial_add_ctrl_fa u_fa (
        .a  (a_sh_r[0]),
        .b  (b_sh_r[0]),
        .ci (carry_r),
        .s  (fa_sum_s),
        .co (fa_co_s),
        .p  (fa_p_s)
    );

`ifdef SERIAL_ADD_EARLY_DONE_EN
    // Zero-filled shifting means only bits above index 0 can still be set.
    assign early_s = !fa_co_s
                     && ((a_sh_r >> 1) == {W{1'b0}})
                     && ((b_sh_r >> 1) == {W{1'b0}});
`else
    assign early_s = 1'b0;
`endif

    assign last_s = (cnt_r == LAST_K) || early_s;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_s = state_r;
        a_sh_s  = a_sh_r;
        b_sh_s  = b_sh_r;
        sum_s   = sum_r;
        carry_s = carry_r;
        cout_s  = cout_r;
        p_s     = p_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (start_valid) begin
                    state_s = RUN;
                    a_sh_s  = a;
                    b_sh_s  = b;
                    carry_s = Cin;
                    sum_s   = {W{1'b0}};
                    p_s     = 1'b1;
                    cnt_s   = {CW{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                sum_s   = sum_r | (W'(fa_sum_s) << cnt_r);
                carry_s = fa_co_s;
                a_sh_s  = a_sh_r >> 1;
                b_sh_s  = b_sh_r >> 1;
                cnt_s   = cnt_r + CW'(1'b1);
                // Skipped upper bits are all-zero pairs, whose propagate is 0.
                if (early_s && (cnt_r != LAST_K)) begin
                    p_s = 1'b0;
                end else begin
                    p_s = p_r & fa_p_s;
                end
                if (last_s) begin
                    state_s = DONE;
                    cout_s  = fa_co_s;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath registers; results hold untouched through IDLE and DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r  <= {W{1'b0}};
            b_sh_r  <= {W{1'b0}};
            sum_r   <= {W{1'b0}};
            carry_r <= 1'b0;
            cout_r  <= 1'b0;
            p_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else begin
            a_sh_r  <= a_sh_s;
            b_sh_r  <= b_sh_s;
            sum_r   <= sum_s;
            carry_r <= carry_s;
            cout_r  <= cout_s;
            p_r     <= p_s;
            cnt_r   <= cnt_s;
        end
    end

    assign start_ready = (state_r == IDLE);
    assign res_valid   = (state_r == DONE);
    assign S           = sum_r;
    assign Cout        = cout_r;
    assign P           = p_r;
    assign cycles      = cnt_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (W=8): directed cases plus a randomized sweep
// compared against an arithmetic reference model.
module tb_serial_add_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_valid;
    logic          start_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          Cin;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  S;
    logic          Cout;
    logic          P;
    logic [CW-1:0] cycles;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .a           (a),
        .b           (b),
        .Cin         (Cin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .S           (S),
        .Cout        (Cout),
        .P           (P),
        .cycles      (cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain W+1-bit arithmetic; group propagate is AND of a^b over all bits,
    // which is also exact when early-done skips all-zero upper bit pairs.
    function automatic void model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                  input logic tc, output logic [W:0] sum,
                                  output logic p, output int cyc);
        logic found;
        sum   = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        p     = &(ta ^ tb);
        cyc   = W;
        found = 1'b0;
`ifdef SERIAL_ADD_EARLY_DONE_EN
        for (int k = 0; k < W; k++) begin
            int unsigned mask, lo, hi;
            mask = (32'd1 << (k + 1)) - 32'd1;
            lo   = ((32'(ta) & mask) + (32'(tb) & mask) + 32'(tc)) >> (k + 1);
            hi   = (32'(ta) >> (k + 1)) | (32'(tb) >> (k + 1));
            if (!found && lo == 0 && hi == 0) begin
                cyc   = k + 1;
                found = 1'b1;
            end
        end
`endif
    endfunction

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        int n = 0;
        a = ta; b = tb; Cin = tc; start_valid = 1'b1;
        while (!start_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("start_wait", 32'(start_ready), 32'd1);
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); Cin = 1'($urandom);
    endtask

    task automatic finish_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                             input int stall);
        logic [W:0] e_sum;
        logic       e_p;
        int         e_cyc;
        int         n = 0;
        model(ta, tb, tc, e_sum, e_p, e_cyc);
        while (!res_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", 32'(n), 32'(e_cyc));
        chk("sum", 32'({Cout, S}), 32'(e_sum));
        chk("prop", 32'(P), 32'(e_p));
        chk("cycles", 32'(cycles), 32'(e_cyc));
        chk("busy_rdy", 32'(start_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            start_valid = 1'($urandom);
            a = W'($urandom); b = W'($urandom); Cin = 1'($urandom);
            @(posedge clk); #1;
            chk("stall_valid", 32'(res_valid), 32'd1);
            chk("stall_sum", 32'({Cout, S}), 32'(e_sum));
            chk("stall_cycles", 32'(cycles), 32'(e_cyc));
            chk("stall_rdy", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_drop", 32'(res_valid), 32'd0);
        chk("idle_rdy", 32'(start_ready), 32'd1);
    endtask

    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                           input int stall);
        start_op(ta, tb, tc);
        finish_op(ta, tb, tc, stall);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; Cin = 1'b0; res_ready = 1'b0;
        #12;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_sum", 32'({Cout, S}), 32'd0);
        chk("rst_p", 32'(P), 32'd0);
        chk("rst_cycles", 32'(cycles), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_rdy", 32'(start_ready), 32'd1);

        run_add(8'hFF, 8'h01, 1'b0, 0);
        run_add(8'h55, 8'hAA, 1'b1, 1);
        run_add(8'h03, 8'h01, 1'b0, 0);
        run_add(8'h00, 8'h00, 1'b0, 0);
        run_add(8'h80, 8'h80, 1'b1, 0);
        // Long result stall with start_valid poked throughout.
        run_add(8'h3C, 8'h47, 1'b1, 5);

        // Reset in the middle of RUN discards the partial result.
        start_op(8'hF0, 8'h0F, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", 32'(res_valid), 32'd0);
        chk("mid_sum", 32'({Cout, S}), 32'd0);
        chk("mid_cycles", 32'(cycles), 32'd0);
        chk("mid_p", 32'(P), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rdy", 32'(start_ready), 32'd1);
        run_add(8'h10, 8'h20, 1'b0, 0);

        for (int t = 0; t < 1000; t++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            if (t % 4 == 0) rb = W'($urandom_range(0, 3));
            run_add(ra, rb, rc, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
